// File: rtl/uart_pkg.sv
// Shared types and line-level constants for the UART console controller.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam int   DATA_BITS = 8;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/uart_fifo.sv
// Small register-array FIFO with a combinational head; one instance each for TX and RX.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2**AW];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head    = mem[rd_ptr[AW-1:0]];
    // A pop in the same cycle frees a slot, so a push on a full FIFO still lands.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_ctrl.sv
// UART console controller: CPU-side FIFOs, 8N1 serialiser and deserialiser.
// tx_ready/rx_avail drive the microcode jump inputs directly.
module uart_ctrl
    import uart_pkg::*;
#(
    parameter int DIVISOR = 16,
    parameter int FIFO_AW = 2
) (
    input  logic       i_clk,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       wr_n,
    input  logic       rd_n,
    output logic [7:0] dout,
    output logic       txd,
    input  logic       rxd,
    output logic       tx_ready,
    output logic       rx_avail,
    output logic       rx_ovf,
    output logic       rx_ferr
);

    localparam int            TW       = $clog2(DIVISOR);
    localparam logic [TW-1:0] BIT_END  = TW'(DIVISOR - 1);
    localparam logic [TW-1:0] HALF_END = TW'(DIVISOR / 2 - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

    logic wr_n_q, rd_n_q;
    logic wr_fall, rd_fall;

    logic [DATA_BITS-1:0] tx_head;
    logic                 tx_full, tx_empty, tx_pop;
    uart_state_t          tx_state;
    logic [TW-1:0]        tx_timer;
    logic [2:0]           tx_bit_cnt;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_bit_end;

    logic [1:0]           rx_sync;
    logic                 rxd_s, rxd_prev;
    logic [DATA_BITS-1:0] rx_head;
    logic                 rx_full, rx_empty, rx_push;
    uart_state_t          rx_state;
    logic [TW-1:0]        rx_timer;
    logic [2:0]           rx_bit_cnt;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_break;
    logic                 rx_bit_end;

    // Strobes act once per high->low transition, however long they stay low.
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            wr_n_q <= 1'b1;
            rd_n_q <= 1'b1;
        end else begin
            wr_n_q <= wr_n;
            rd_n_q <= rd_n;
        end
    end

    assign wr_fall = wr_n_q && !wr_n;
    assign rd_fall = rd_n_q && !rd_n;

    uart_fifo #(.WIDTH(DATA_BITS), .AW(FIFO_AW)) u_tx_fifo (
        .clk   (i_clk),
        .rst_n (reset),
        .push  (wr_fall),
        .pop   (tx_pop),
        .wdata (din),
        .head  (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    assign tx_bit_end = (tx_timer == BIT_END);
    assign tx_pop     = !tx_empty && ((tx_state == IDLE) || (tx_state == STOP && tx_bit_end));

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            tx_state   <= IDLE;
            tx_timer   <= '0;
            tx_bit_cnt <= '0;
            tx_shift   <= '0;
            txd        <= STOP_LVL;
        end else begin
            case (tx_state)
                IDLE: begin
                    if (!tx_empty) begin
                        tx_state <= START;
                        tx_shift <= tx_head;
                        tx_timer <= '0;
                        txd      <= START_LVL;
                    end
                end
                START: begin
                    if (tx_bit_end) begin
                        tx_state   <= DATA;
                        tx_timer   <= '0;
                        tx_bit_cnt <= '0;
                        txd        <= tx_shift[0];
                    end else begin
                        tx_timer <= tx_timer + TW'(1);
                    end
                end
                DATA: begin
                    if (tx_bit_end) begin
                        tx_timer <= '0;
                        if (tx_bit_cnt == LAST_BIT) begin
                            tx_state <= STOP;
                            txd      <= STOP_LVL;
                        end else begin
                            tx_bit_cnt <= tx_bit_cnt + 3'd1;
                            tx_shift   <= tx_shift >> 1;
                            txd        <= tx_shift[1];
                        end
                    end else begin
                        tx_timer <= tx_timer + TW'(1);
                    end
                end
                STOP: begin
                    if (tx_bit_end) begin
                        tx_timer <= '0;
                        // Chain straight into the next start bit when more data waits.
                        if (!tx_empty) begin
                            tx_state <= START;
                            tx_shift <= tx_head;
                            txd      <= START_LVL;
                        end else begin
                            tx_state <= IDLE;
                        end
                    end else begin
                        tx_timer <= tx_timer + TW'(1);
                    end
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

    // rxd is asynchronous; two flops before anything looks at it.
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            rx_sync  <= 2'b11;
            rxd_prev <= 1'b1;
        end else begin
            rx_sync  <= {rx_sync[0], rxd};
            rxd_prev <= rxd_s;
        end
    end

    assign rxd_s      = rx_sync[1];
    assign rx_bit_end = (rx_timer == BIT_END);
    assign rx_push    = (rx_state == STOP) && !rx_break && rx_bit_end && (rxd_s == STOP_LVL);

    uart_fifo #(.WIDTH(DATA_BITS), .AW(FIFO_AW)) u_rx_fifo (
        .clk   (i_clk),
        .rst_n (reset),
        .push  (rx_push),
        .pop   (rd_fall),
        .wdata (rx_shift),
        .head  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            rx_state   <= IDLE;
            rx_timer   <= '0;
            rx_bit_cnt <= '0;
            rx_shift   <= '0;
            rx_break   <= 1'b0;
            rx_ovf     <= 1'b0;
            rx_ferr    <= 1'b0;
        end else begin
            case (rx_state)
                IDLE: begin
                    if (rxd_prev && !rxd_s) begin
                        rx_state <= START;
                        rx_timer <= '0;
                    end
                end
                START: begin
                    if (rx_timer == HALF_END) begin
                        rx_timer   <= '0;
                        rx_bit_cnt <= '0;
                        rx_state   <= (rxd_s == START_LVL) ? DATA : IDLE;
                    end else begin
                        rx_timer <= rx_timer + TW'(1);
                    end
                end
                DATA: begin
                    if (rx_bit_end) begin
                        rx_timer <= '0;
                        rx_shift <= {rxd_s, rx_shift[DATA_BITS-1:1]};
                        if (rx_bit_cnt == LAST_BIT) rx_state <= STOP;
                        else                        rx_bit_cnt <= rx_bit_cnt + 3'd1;
                    end else begin
                        rx_timer <= rx_timer + TW'(1);
                    end
                end
                STOP: begin
                    // After a framing error, hold here until the line is idle again.
                    if (rx_break) begin
                        if (rxd_s == STOP_LVL) begin
                            rx_break <= 1'b0;
                            rx_state <= IDLE;
                        end
                    end else if (rx_bit_end) begin
                        if (rxd_s == STOP_LVL) begin
                            rx_state <= IDLE;
                            if (rx_full && !rd_fall) rx_ovf <= 1'b1;
                        end else begin
                            rx_ferr  <= 1'b1;
                            rx_break <= 1'b1;
                        end
                    end else begin
                        rx_timer <= rx_timer + TW'(1);
                    end
                end
                default: rx_state <= IDLE;
            endcase
        end
    end

    assign tx_ready = !tx_full;
    assign rx_avail = !rx_empty;
    assign dout     = rx_empty ? 8'h00 : rx_head;

endmodule

// File: tb/tb_uart_ctrl.sv
// Bench for uart_ctrl: directed stimulus, scoreboard queues checked by TX/RX monitors.
module tb_uart_ctrl;

    localparam int DIVISOR = 4;
    localparam int FIFO_AW = 2;
    localparam int FRAME   = 10 * DIVISOR;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din   = 8'h00;
    logic       wr_n  = 1'b1;
    logic       rd_n  = 1'b1;
    logic       rxd   = 1'b1;
    logic [7:0] dout;
    logic       txd, tx_ready, rx_avail, rx_ovf, rx_ferr;

    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc          = 0;
    int tx_frames    = 0;

    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];
    int         tx_starts[$];
    bit         tx_mon_en = 1'b1;
    bit         auto_read = 1'b0;

    uart_ctrl #(.DIVISOR(DIVISOR), .FIFO_AW(FIFO_AW)) dut (
        .i_clk    (clk),
        .reset    (rst_n),
        .din      (din),
        .wr_n     (wr_n),
        .rd_n     (rd_n),
        .dout     (dout),
        .txd      (txd),
        .rxd      (rxd),
        .tx_ready (tx_ready),
        .rx_avail (rx_avail),
        .rx_ovf   (rx_ovf),
        .rx_ferr  (rx_ferr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // One CPU write strobe: wr_n low for a single cycle.
    task automatic applyStimulus(input logic [7:0] data);
        @(negedge clk);
        din  = data;
        wr_n = 1'b0;
        @(negedge clk);
        wr_n = 1'b1;
    endtask

    task automatic sendRxFrame(input logic [7:0] data, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, data, 1'b0};
        @(negedge clk);
        for (int j = 0; j < 10; j++) begin
            rxd = bits[j];
            repeat (DIVISOR) @(negedge clk);
        end
        rxd = 1'b1;
    endtask

    task automatic waitTxDrain(input int budget);
        int n = 0;
        while (tx_exp.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("tx_drain_pending", 64'(tx_exp.size()), 64'd0);
        tx_exp.delete();
    endtask

    task automatic waitRxDrain(input int budget);
        int n = 0;
        while (rx_exp.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rx_drain_pending", 64'(rx_exp.size()), 64'd0);
        rx_exp.delete();
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_txd"},      64'(txd),      64'd1);
        checkOutput({tag, "_tx_ready"}, 64'(tx_ready), 64'd1);
        checkOutput({tag, "_rx_avail"}, 64'(rx_avail), 64'd0);
        checkOutput({tag, "_dout"},     64'(dout),     64'd0);
        checkOutput({tag, "_rx_ovf"},   64'(rx_ovf),   64'd0);
        checkOutput({tag, "_rx_ferr"},  64'(rx_ferr),  64'd0);
    endtask

    // TX monitor: decodes txd at mid-bit and checks against the expected-byte queue.
    initial begin : tx_monitor
        logic [7:0] b;
        logic       stop_v;
        forever begin
            @(negedge clk);
            if (tx_mon_en && txd == 1'b0) begin
                tx_starts.push_back(cyc);
                repeat (DIVISOR / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIVISOR) @(negedge clk);
                    b[i] = txd;
                end
                repeat (DIVISOR) @(negedge clk);
                stop_v = txd;
                tx_frames++;
                if (tx_exp.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("[TB] FAIL tx_unexpected: got byte 0x%02h, required no frame", b);
                end else begin
                    checkOutput("tx_byte", 64'(b), 64'(tx_exp.pop_front()));
                end
                checkOutput("tx_stop", 64'(stop_v), 64'd1);
            end
        end
    end

    // RX monitor: acting as the CPU, reads each available byte and checks it.
    initial begin : rx_monitor
        logic [7:0] exp_b;
        forever begin
            @(negedge clk);
            if (auto_read && rx_avail) begin
                if (rx_exp.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("[TB] FAIL rx_unexpected: got byte 0x%02h, required none", dout);
                end else begin
                    exp_b = rx_exp.pop_front();
                    checkOutput("rx_byte", 64'(dout), 64'(exp_b));
                end
                rd_n = 1'b0;
                @(negedge clk);
                rd_n = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [41:0] wave_act;
        logic [41:0] wave_exp;
        logic [7:0]  a5;
        int          pos;
        int          n;

        repeat (3) @(negedge clk);
        checkResetValues("reset_init");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] single TX byte 0xA5");
        a5 = 8'hA5;
        tx_exp.push_back(a5);
        applyStimulus(a5);
        wave_act[0] = txd;
        for (int i = 1; i < 42; i++) begin
            @(negedge clk);
            wave_act[i] = txd;
        end
        wave_exp[0]  = 1'b1;
        wave_exp[41] = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            pos = (i - 1) / DIVISOR;
            if (pos == 0)      wave_exp[i] = 1'b0;
            else if (pos == 9) wave_exp[i] = 1'b1;
            else               wave_exp[i] = a5[pos-1];
        end
        checkOutput("tx_wave_a5", 64'(wave_act), 64'(wave_exp));
        waitTxDrain(FRAME);

        $display("[TB] TX FIFO full: six back-to-back pushes");
        tx_starts.delete();
        for (int i = 1; i <= 6; i++) begin
            if (i <= 5) tx_exp.push_back(8'(i));
            applyStimulus(8'(i));
            if (i == 4) checkOutput("tx_ready_before_full", 64'(tx_ready), 64'd1);
            if (i >= 5) checkOutput("tx_ready_full", 64'(tx_ready), 64'd0);
        end
        waitTxDrain(6 * FRAME);
        repeat (FRAME + 10) @(negedge clk);
        checkOutput("tx_frame_count", 64'(tx_starts.size()), 64'd5);
        for (int i = 1; i < tx_starts.size(); i++)
            checkOutput("tx_b2b_gap", 64'(tx_starts[i] - tx_starts[i-1]), 64'(FRAME));
        checkOutput("tx_ready_drained", 64'(tx_ready), 64'd1);

        $display("[TB] held write strobe");
        n = tx_frames;
        tx_exp.push_back(8'h55);
        @(negedge clk);
        din  = 8'h55;
        wr_n = 1'b0;
        repeat (3) @(negedge clk);
        wr_n = 1'b1;
        waitTxDrain(FRAME + 10);
        repeat (FRAME + 10) @(negedge clk);
        checkOutput("held_strobe_frames", 64'(tx_frames - n), 64'd1);

        $display("[TB] RX byte 0x3C");
        sendRxFrame(8'h3C, 1'b1);
        checkOutput("rx_avail_at_stop", 64'(rx_avail), 64'd0);
        @(negedge clk);
        checkOutput("rx_avail_after_stop", 64'(rx_avail), 64'd1);
        checkOutput("rx_dout_3c", 64'(dout), 64'h3C);
        rx_exp.push_back(8'h3C);
        auto_read = 1'b1;
        waitRxDrain(20);
        auto_read = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rx_avail_after_read", 64'(rx_avail), 64'd0);
        checkOutput("rx_dout_after_read", 64'(dout), 64'd0);

        $display("[TB] RX glitch rejection");
        @(negedge clk);
        rxd = 1'b0;
        repeat (2) @(negedge clk);
        rxd = 1'b1;
        repeat (FRAME + 10) @(negedge clk);
        checkOutput("glitch_rx_avail", 64'(rx_avail), 64'd0);
        checkOutput("glitch_rx_ferr", 64'(rx_ferr), 64'd0);

        $display("[TB] RX framing error then recovery");
        sendRxFrame(8'h7E, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("ferr_flag", 64'(rx_ferr), 64'd1);
        checkOutput("ferr_rx_avail", 64'(rx_avail), 64'd0);
        rx_exp.push_back(8'h5A);
        auto_read = 1'b1;
        sendRxFrame(8'h5A, 1'b1);
        waitRxDrain(20);
        auto_read = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("ferr_sticky", 64'(rx_ferr), 64'd1);

        $display("[TB] RX overflow: five frames, no reads");
        for (int i = 0; i < 5; i++) begin
            sendRxFrame(8'h11 + 8'(i), 1'b1);
            if (i < 4) rx_exp.push_back(8'h11 + 8'(i));
            if (i == 3) begin
                repeat (2) @(negedge clk);
                checkOutput("ovf_before_fifth", 64'(rx_ovf), 64'd0);
            end
        end
        repeat (2) @(negedge clk);
        checkOutput("ovf_flag", 64'(rx_ovf), 64'd1);
        checkOutput("ovf_rx_avail", 64'(rx_avail), 64'd1);
        auto_read = 1'b1;
        waitRxDrain(40);
        auto_read = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("ovf_drained_avail", 64'(rx_avail), 64'd0);

        $display("[TB] reset mid-frame");
        tx_mon_en = 1'b0;
        applyStimulus(8'h00);
        @(negedge clk);
        rxd = 1'b0;
        repeat (14) @(negedge clk);
        checkOutput("tx_midframe_low", 64'(txd), 64'd0);
        rst_n = 1'b0;
        #1;
        checkResetValues("reset_mid");
        repeat (2) @(negedge clk);
        rxd = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        n = tx_frames;
        tx_mon_en = 1'b1;
        repeat (FRAME + 10) @(negedge clk);
        checkResetValues("after_reset");
        checkOutput("after_reset_tx_frames", 64'(tx_frames - n), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
